chi_inv_seq: RTL and testbench
==============================

# chi_inv_seq

Sequential inverse of the Keccak-f[1600] chi step. Accepts a 1600-bit state through a valid/ready handshake, inverts chi row by row with a 32-entry row lookup, processing a configurable number of bit-slices per cycle, and returns the pre-chi state through an output handshake. It sits beside the forward chi step for round-trip verification and inverse-permutation use. It trades latency for area against a fully parallel inverse.

## Interface
- SLICES_PER_CYCLE, default 8: number of z positions (0..63) processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64; any other value is an elaboration error. N = 64 / SLICES_PER_CYCLE processing cycles.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous and active-high.
- enable  input  1  global advance; when low, all registers hold, including the FSM, counter, work register and outputs.
- in_valid  input  1  state_in is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- state_in  input  1600  chi output state. Lane x+5y occupies bits [(x+5y)*64 +: 64]; bit z is lane bit z.
- out_valid  output  1  state_out holds a completed result.
- out_ready  input  1  downstream accepts the result.
- state_out  output  1600  inverted state, same packing; driven directly from the work register.

## Operation
- Forward map on row (y,z), x=0..4: b[x] = a[x] ^ (~a[(x+1)%5] & a[(x+2)%5]). Row value packs bit x of the row into bit x of a 5-bit index.
- LUT: inv[chi(a)] = a for all 32 a. LUT is a constant function or case statement.
- Known entries:
  - inv[0x00]=0x00
  - inv[0x1F]=0x1F
  - inv[0x09]=0x01
- FSM states:
  - IDLE: in_ready=1. On in_valid && enable, load work register from state_in, clear slice counter, go to BUSY.
  - BUSY: each enabled cycle, replace z range [cnt*S, cnt*S+S) of all 25 lanes with inv(row) for all 5 y-rows. cnt increments. After the slice with cnt=N-1, go to DONE.
  - DONE: out_valid=1. On out_ready && enable, go to IDLE. The counter is already 0 or don't-care.
- Slice counter width is clog2(N), minimum 1 bit. It wraps at N-1 to 0.
- Rows in different slices are independent. The in-place update is therefore exact.
- state_out is stable throughout DONE and keeps its last value after returning to IDLE. Downstream must only sample it when out_valid is high.
- No new input is accepted in BUSY or DONE; in_valid is ignored there.

## Timing
- Reset values:
  - state = IDLE
  - in_ready=1
  - out_valid=0
  - state_out = 0 (1600'b0)
  - counter=0
- rst has priority over enable.
- Latency: input accepted at edge k. BUSY occupies edges k+1..k+N. out_valid is high from edge k+N onward. With the default S=8, out_valid is high 8 cycles after acceptance.
- Output handshake completes on the edge where out_valid && out_ready && enable. in_ready is high the cycle after that edge. The minimum back-to-back period is N+2 cycles.
- enable low in any state freezes everything. It extends latency by exactly the number of low cycles.
- rst asserted mid-BUSY or in DONE aborts the operation: outputs return to reset values at the next edge and the partial result is discarded.
- in_valid asserted during the same cycle as a DONE handshake is not accepted. It is accepted on the following IDLE cycle.

## Test plan
- Reset then idle: assert rst for 2 cycles -> in_ready=1, out_valid=0, state_out=0.
- Fixed points: state_in all-zeros, then state_in all-ones -> each state_out equals its input. out_valid rises exactly N=8 cycles after acceptance.
- Single row: state_in with lane 0 bit 0 and lane 3 bit 0 set, all else 0 (row (0,0) = 0x09) -> state_out has only lane 0 bit 0 set. Repeat at z=63, y=4 (lanes 20 and 23) for S=1, 8 and 64.
- Round trip: 200 random states pass through chi_inv_seq and then through a forward chi model -> each result equals the original. Also pass random states through forward chi and then chi_inv_seq -> each result equals the original.
- Stalls and backpressure: hold enable low for 3 cycles mid-BUSY and hold out_ready low for 5 cycles in DONE -> out_valid rises at 8+3 cycles, state_out is stable while waiting, and in_ready stays low until the handshake.
- Abort: assert rst at BUSY cycle 4 -> state_out=0 and in_ready=1 next cycle. A subsequent new input then completes correctly.

Source files
------------

// File: rtl/chi_inv_seq.sv
// chi_inv_seq: inverts the Keccak chi step over a 1600-bit state, a few bit-slices per cycle.
module chi_inv_seq #(
  parameter int SLICES_PER_CYCLE = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1599:0] state_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1599:0] state_out
);
  localparam int S  = SLICES_PER_CYCLE;
  localparam int N  = 64 / S;
  localparam int CW = N > 1 ? $clog2(N) : 1;

  if (!(S == 1 || S == 2 || S == 4 || S == 8 || S == 16 || S == 32 || S == 64)) begin : g_bad_slices
    $error("chi_inv_seq: SLICES_PER_CYCLE must be a power of two from 1 to 64");
  end

  function automatic logic [4:0] chi5(input logic [4:0] a);
    chi5 = '0;
    for (int x = 0; x < 5; x++) chi5[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
  endfunction

  // Inverse table built at elaboration by scattering each preimage to its chi image.
  function automatic logic [159:0] build_lut();
    logic [159:0] t;
    t = '0;
    for (int a = 0; a < 32; a++) t[5 * chi5(5'(a)) +: 5] = 5'(a);
    return t;
  endfunction

  localparam logic [159:0] LUT = build_lut();

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1599:0] work, work_d, upd;
  logic [4:0]    row;
  int            z;

  // Slices are disjoint row sets, so rewriting them in place is exact.
  always_comb begin
    upd = work;
    row = '0;
    z   = 0;
    for (int j = 0; j < S; j++) begin
      z = int'(cnt) * S + j;
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 5; x++) row[x] = work[(x + 5 * y) * 64 + z];
        for (int x = 0; x < 5; x++) upd[(x + 5 * y) * 64 + z] = LUT[5 * row + x];
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    work_d  = work;
    if (enable) begin
      case (state)
        IDLE: if (in_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
          work_d  = state_in;
        end
        BUSY: begin
          work_d  = upd;
          cnt_d   = (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
          state_d = (cnt == CW'(N - 1)) ? DONE : BUSY;
        end
        DONE:    state_d = out_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      work  <= work_d;
    end
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign state_out = work;
endmodule

// File: tb/tb_chi_inv_seq.sv
// tb_chi_inv_seq: scoreboard bench for chi_inv_seq (S=8 main, S=1 and S=64 for single-row cases).
module tb_chi_inv_seq;
  logic          clk = 0, rst = 1, enable = 1, in_valid = 0, out_ready = 0;
  logic [1599:0] state_in = '0;
  logic          in_ready, out_valid, in_ready1, out_valid1, in_ready64, out_valid64;
  logic [1599:0] state_out, state_out1, state_out64;
  int            n_chk = 0, n_fail = 0;

  typedef struct {
    logic [1599:0] exp;
    bit            fwd;
  } item_t;
  item_t sb[$];

  always #5 clk = ~clk;

  chi_inv_seq #(.SLICES_PER_CYCLE(8)) dut (.clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out));
  chi_inv_seq #(.SLICES_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready1), .state_in(state_in), .out_valid(out_valid1), .out_ready(out_ready), .state_out(state_out1));
  chi_inv_seq #(.SLICES_PER_CYCLE(64)) dut64 (.clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready64), .state_in(state_in), .out_valid(out_valid64), .out_ready(out_ready), .state_out(state_out64));

  task automatic chk(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
    int l;
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      l = 0;
      for (int i = 24; i >= 0; i--) if (got[i*64 +: 64] !== exp[i*64 +: 64]) l = i;
      $display("FAIL %s: lane %0d got %h expected %h", tag, l, got[l*64 +: 64], exp[l*64 +: 64]);
    end
  endtask

  function automatic logic [1599:0] chi_fwd(input logic [1599:0] s);
    logic [1599:0] o;
    o = '0;
    for (int y = 0; y < 5; y++)
      for (int z = 0; z < 64; z++)
        for (int x = 0; x < 5; x++)
          o[(x + 5*y)*64 + z] = s[(x + 5*y)*64 + z] ^
            (~s[((x + 1) % 5 + 5*y)*64 + z] & s[((x + 2) % 5 + 5*y)*64 + z]);
    return o;
  endfunction

  function automatic logic [1599:0] rnd();
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && enable && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        item_t it;
        it = sb.pop_front();
        chk("result", it.fwd ? chi_fwd(state_out) : state_out, it.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [1599:0] d, input logic [1599:0] e, input bit fwd, input int stall, input int bp);
    int c;
    logic [1599:0] snap;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1;
    state_in = d;
    sb.push_back('{e, fwd});
    tick();
    in_valid = 0;
    chk("in_ready_busy", in_ready, 0);
    c = 0;
    while (!out_valid && c < 200) begin
      enable = !(stall > 0 && c >= 3 && c < 3 + stall);
      tick();
      c++;
    end
    enable = 1;
    chk("latency", c, 8 + stall);
    snap = state_out;
    in_valid = 1;
    repeat (bp) tick();
    chk("hold_valid", out_valid, 1);
    chk("hold_data", state_out, snap);
    chk("hold_in_ready", in_ready, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("post_hs_in_ready", in_ready, 1);
    in_valid = 0;
  endtask

  task automatic row_test(input logic [1599:0] d, input logic [1599:0] e);
    int c;
    rst = 1;
    tick();
    rst = 0;
    in_valid = 1;
    state_in = d;
    sb.push_back('{e, 1'b0});
    tick();
    in_valid = 0;
    c = 0;
    while (!(out_valid && out_valid1 && out_valid64) && c < 200) begin
      tick();
      c++;
    end
    chk("row_s8", state_out, e);
    chk("row_s1", state_out1, e);
    chk("row_s64", state_out64, e);
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    logic [1599:0] d, e, r;
    rst = 1;
    repeat (2) tick();
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_state_out", state_out, '0);
    xfer('0, '0, 0, 0, 0);
    xfer('1, '1, 0, 0, 0);
    d = '0; d[0] = 1; d[3*64] = 1;
    e = '0; e[0] = 1;
    row_test(d, e);
    d = '0; d[20*64 + 63] = 1; d[23*64 + 63] = 1;
    e = '0; e[20*64 + 63] = 1;
    row_test(d, e);
    r = rnd();
    xfer(r, r, 1, 3, 5);
    for (int i = 0; i < 200; i++) begin
      r = rnd();
      xfer(r, r, 1, 0, 0);
    end
    for (int i = 0; i < 200; i++) begin
      r = rnd();
      xfer(chi_fwd(r), r, 0, 0, 0);
    end
    in_valid = 1;
    state_in = rnd();
    tick();
    in_valid = 0;
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_state_out", state_out, '0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    r = rnd();
    xfer(r, r, 1, 0, 0);
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
